branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Parametrised branch resolution stage for the LEGv8 pipeline; successor to the single-cycle branch source selector.
- Holds the architectural NZCV register and evaluates all 16 B.cond condition codes.
- Performs true register-zero CBZ/CBNZ compares and compares each outcome with the fetch-stage prediction.
- On a mispredict, issues a registered PC redirect, then squashes a configurable number of younger slots through a small flush state machine; also counts mispredicts.

Parameters:
- DATA_W, 64, width of rt_value compared by CBZ/CBNZ
- ADDR_W, 64, PC width
- FLUSH_CYCLES, 2, younger slots squashed after a redirect (1..15)
- FLAG_BYPASS, 1, 1 = B.cond in the same cycle as setflags sees flags_in; 0 = sees flags_q only
- CNT_W, 16, mispredict counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low
- valid_in  in  1  instruction in resolve slot is valid
- stall  in  1  hold all state; no outputs change
- branch_op  in  BRANCHOP_SIZE  NONE/B/BR/BL/CBZ/CBNZ/BCOND
- cond_code  in  4  B.cond field (EQ=0 .. NV=15)
- setflags  in  1  update flag register from flags_in
- flags_in  in  4  {N,Z,C,V} from ALU
- rt_value  in  DATA_W  register operand for CBZ/CBNZ
- pc_branch  in  ADDR_W  PC + sign-extended offset
- pc_aluout  in  ADDR_W  register target for BR
- pc_plus4  in  ADDR_W  fall-through PC
- predicted_taken  in  1  fetch-stage prediction for this slot
- branch_sel  out  2  NOOP=0 / PCBRANCH=1 / PCALUOUT=2, combinational
- taken  out  1  resolved direction, combinational
- link_we  out  1  BL resolved this cycle (X30 write enable), combinational
- redirect_valid  out  1  registered one-cycle redirect pulse
- redirect_pc  out  ADDR_W  registered corrected PC
- squash  out  1  high while younger slots are being flushed
- flags_q  out  4  architectural NZCV
- mispredict_cnt  out  CNT_W  saturating mispredict count

Behaviour:
- Reset (reset==0 at an edge): flags_q=0, redirect_valid=0, redirect_pc=0, squash=0, mispredict_cnt=0, state=IDLE. Reset has priority over stall. Reset mid-flush aborts the flush.
- Effective slot: eff = valid_in & ~squash & ~stall. Combinational outputs are 0 when eff=0.
- Flags: on an edge with eff & setflags, flags_q <= flags_in. A squashed or stalled setflags is ignored.
- Flag source for condition evaluation: fsrc = (FLAG_BYPASS & setflags) ? flags_in : flags_q.
- Condition table:
  - EQ/NE: Z / !Z
  - CS/CC: C / !C
  - MI/PL: N / !N
  - VS/VC: V / !V
  - HI: C&!Z; LS: !(C&!Z)
  - GE: N==V; LT: N!=V
  - GT: !Z&(N==V); LE: !(!Z&(N==V))
  - AL and NV: always true
- Direction:
  - B, BL, BR: taken=1
  - CBZ: taken = (rt_value==0); CBNZ: taken = (rt_value!=0), full DATA_W compare
  - BCOND: taken = cond result
  - NONE: taken=0
- branch_sel: BR taken -> PCALUOUT; other taken -> PCBRANCH; else NOOP.
- Mispredict: mp = eff & (taken != predicted_taken). BR counts as a mispredict whenever eff, because the fetch stage cannot know a register target.
- Redirect: on an edge with mp, redirect_valid <= 1 for exactly one cycle and redirect_pc <= taken ? (BR ? pc_aluout : pc_branch) : pc_plus4.
- Flush state machine:
  - IDLE -> FLUSH on mp, loading cnt=FLUSH_CYCLES.
  - FLUSH: squash=1; cnt decrements on each non-stalled edge; return to IDLE when cnt reaches 1 at an edge.
  - Stall freezes cnt and holds redirect_valid high.
  - valid_in is ignored while squash=1, so back-to-back mispredicts cannot occur.
- mispredict_cnt: increments on each mp edge; saturates at all-ones.

Decomposition:
- Shared package branch_pkg: branch_op enum (values from branch.svh), branch_sel encoding NOOP/PCBRANCH/PCALUOUT, cond_code enum (EQ..NV), flag bit indices N=3/Z=2/C=1/V=0, flush state enum.
- One sub-module, cond_eval: purely combinational, 4-bit NZCV + 4-bit cond_code -> 1-bit result. It is unit-tested exhaustively.

Test Plan:
- Reset, then setflags=1 with flags_in=4'b0100 -> flags_q=4'b0100 next cycle. BCOND EQ with setflags=0 -> taken=1. NE -> taken=0.
- cond_eval sweep: all 16 conds x 16 NZCV values match the table. Spot checks: N=1,V=0 -> GE=0, LT=1. C=1,Z=0 -> HI=1.
- CBZ with rt_value=64'h0 and predicted_taken=0 -> mp. Next cycle: redirect_valid=1, redirect_pc=pc_branch, squash=1 for 2 cycles. mispredict_cnt=1.
- BR with pc_aluout=64'h400 -> branch_sel=2. Next cycle: redirect_pc=64'h400. A valid CBNZ arriving during squash -> taken=0, no counter change.
- FLAG_BYPASS=1: setflags with flags_in Z=1 and BCOND EQ in the same cycle -> taken=1. With FLAG_BYPASS=0 and flags_q Z=0 -> taken=0.
- Stall held 3 cycles mid-FLUSH -> squash and cnt frozen. Assert reset during FLUSH -> squash=0, redirect_valid=0 next edge. CNT_W=2 with 5 mispredicts -> cnt saturates at 3.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and encodings for the branch resolve stage
package branch_pkg;

  localparam int BRANCHOP_SIZE = 3;

  typedef enum logic [BRANCHOP_SIZE-1:0] {
    OP_NONE  = 3'd0,
    OP_B     = 3'd1,
    OP_BR    = 3'd2,
    OP_BL    = 3'd3,
    OP_CBZ   = 3'd4,
    OP_CBNZ  = 3'd5,
    OP_BCOND = 3'd6
  } branch_op_e;

  typedef enum logic [1:0] {
    SEL_NOOP     = 2'd0,
    SEL_PCBRANCH = 2'd1,
    SEL_PCALUOUT = 2'd2
  } branch_sel_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_code_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational B.cond evaluation of NZCV against a condition code
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] nzcv,
  input  logic [3:0] cond,
  output logic       result
);

  logic n, z, c, v;
  logic base;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // Conditions come in pairs; the odd code of each pair is the inverse, except AL/NV which are both true
  always_comb begin
    base = 1'b1;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    result = (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch resolution, mispredict redirect and younger-slot flush
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int FLAG_BYPASS  = 1,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic                     stall,
  input  logic [BRANCHOP_SIZE-1:0] branch_op,
  input  logic [3:0]               cond_code,
  input  logic                     setflags,
  input  logic [3:0]               flags_in,
  input  logic [DATA_W-1:0]        rt_value,
  input  logic [ADDR_W-1:0]        pc_branch,
  input  logic [ADDR_W-1:0]        pc_aluout,
  input  logic [ADDR_W-1:0]        pc_plus4,
  input  logic                     predicted_taken,
  output logic [1:0]               branch_sel,
  output logic                     taken,
  output logic                     link_we,
  output logic                     redirect_valid,
  output logic [ADDR_W-1:0]        redirect_pc,
  output logic                     squash,
  output logic [3:0]               flags_q,
  output logic [CNT_W-1:0]         mispredict_cnt
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  flush_state_e state, state_nxt;
  logic [3:0]   cnt, cnt_nxt;
  logic         eff, mp, is_br, raw_taken, cond_res;
  logic [3:0]   fsrc;

  assign eff   = valid_in & ~squash & ~stall;
  assign is_br = (branch_op == OP_BR);
  assign fsrc  = ((FLAG_BYPASS != 0) && setflags) ? flags_in : flags_q;

  cond_eval u_cond_eval (
    .nzcv   (fsrc),
    .cond   (cond_code),
    .result (cond_res)
  );

  // Resolve the raw branch direction independent of slot validity
  always_comb begin
    raw_taken = 1'b0;
    case (branch_op)
      OP_B, OP_BL, OP_BR: raw_taken = 1'b1;
      OP_CBZ:             raw_taken = (rt_value == '0);
      OP_CBNZ:            raw_taken = (rt_value != '0);
      OP_BCOND:           raw_taken = cond_res;
      default:            raw_taken = 1'b0;
    endcase
  end

  assign taken   = eff & raw_taken;
  assign link_we = eff & (branch_op == OP_BL);
  // A register target is never known at fetch, so BR always redirects
  assign mp      = eff & ((taken != predicted_taken) | is_br);

  // Select the PC source for a taken branch
  always_comb begin
    branch_sel = SEL_NOOP;
    if (taken) branch_sel = is_br ? SEL_PCALUOUT : SEL_PCBRANCH;
  end

  // Architectural NZCV: only effective setflags slots update it
  always_ff @(posedge clk) begin
    if (!reset)                flags_q <= '0;
    else if (eff && setflags)  flags_q <= flags_in;
  end

  // One-cycle redirect pulse with the corrected PC; stall holds it
  always_ff @(posedge clk) begin
    if (!reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (!stall) begin
      redirect_valid <= mp;
      if (mp) redirect_pc <= taken ? (is_br ? pc_aluout : pc_branch) : pc_plus4;
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge clk) begin
    if (!reset)                          mispredict_cnt <= '0;
    else if (mp && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 1'b1;
  end

  // Flush state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Flush next state: load on mispredict, count down on non-stalled edges
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (mp) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          if (cnt == 4'd1) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Flush outputs
  always_comb begin
    squash = (state == ST_FLUSH);
  end

endmodule
